// File: rtl/hs_frame_switch_mux_if.sv
// rtl/hs_frame_switch_mux_if.sv - handshake bundle for hs_frame_switch_mux
//
// Purpose: groups the INPUTS input streams and the single output stream.
// Ports (signals):
//   dataIn_data  INPUTS*DATA_WIDTH  input i at [i*DATA_WIDTH +: DATA_WIDTH]
//   dataIn_last  INPUTS             end-of-frame per input
//   dataIn_vld   INPUTS             valid per input
//   dataIn_rd    INPUTS             ready per input
//   dataOut_data DATA_WIDTH         output beat
//   dataOut_last 1                  output end-of-frame
//   dataOut_vld  1                  output valid
//   dataOut_rd   1                  output ready
// Modports: slave = the mux, master = producers/consumer around it.
interface hs_frame_switch_mux_if #(
    parameter int INPUTS     = 3,
    parameter int DATA_WIDTH = 8
);
    logic [INPUTS*DATA_WIDTH-1:0] dataIn_data;
    logic [INPUTS-1:0]            dataIn_last;
    logic [INPUTS-1:0]            dataIn_vld;
    logic [INPUTS-1:0]            dataIn_rd;
    logic [DATA_WIDTH-1:0]        dataOut_data;
    logic                         dataOut_last;
    logic                         dataOut_vld;
    logic                         dataOut_rd;

    modport slave (
        input  dataIn_data, dataIn_last, dataIn_vld, dataOut_rd,
        output dataIn_rd, dataOut_data, dataOut_last, dataOut_vld
    );

    modport master (
        output dataIn_data, dataIn_last, dataIn_vld, dataOut_rd,
        input  dataIn_rd, dataOut_data, dataOut_last, dataOut_vld
    );
endinterface

// File: rtl/hs_frame_switch_mux.sv
// rtl/hs_frame_switch_mux.sv - frame-locked handshaked stream multiplexer
//
// Purpose: forwards one of INPUTS valid/ready streams, chosen by sel, through
// a single registered output stage. The choice is held for a whole frame so
// frames from different inputs never interleave.
// Ports:
//   clk      rising-edge clock
//   rst      synchronous active-high reset
//   sel      requested input, only looked at while idle
//   bus      hs_frame_switch_mux_if.slave (input streams + output stream)
//   locked   high while a frame is in progress
//   cur_sel  input the current/last frame came from
//   sel_err  sticky flag: out-of-range sel was seen while idle
module hs_frame_switch_mux #(
    parameter int INPUTS     = 3,
    parameter int DATA_WIDTH = 8,
    parameter int SEL_WIDTH  = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [SEL_WIDTH-1:0] sel,
    hs_frame_switch_mux_if.slave bus,
    output logic                 locked,
    output logic [SEL_WIDTH-1:0] cur_sel,
    output logic                 sel_err
);
    typedef enum logic {
        S_IDLE   = 1'b0,
        S_LOCKED = 1'b1
    } state_t;

    localparam logic [SEL_WIDTH:0] INPUTS_W = (SEL_WIDTH+1)'(INPUTS);

    state_t                state_q, state_d;
    logic [SEL_WIDTH-1:0]  cur_sel_q, cur_sel_d;
    logic                  sel_err_q, sel_err_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic                  out_last_q, out_last_d;
    logic                  out_vld_q, out_vld_d;

    logic [SEL_WIDTH-1:0]  act;
    logic                  act_ok;
    logic                  space;
    logic [INPUTS-1:0]     rd;
    logic [DATA_WIDTH-1:0] act_data;
    logic                  act_last;
    logic                  accept;

    // Input routing: the active index is the live sel while idle and the
    // latched one during a frame, so a new sel acts in the same cycle.
    always_comb begin
        act      = (state_q == S_LOCKED) ? cur_sel_q : sel;
        act_ok   = ({1'b0, act} < INPUTS_W);
        space    = !out_vld_q || bus.dataOut_rd;
        rd       = '0;
        act_data = '0;
        act_last = 1'b0;
        for (int i = 0; i < INPUTS; i++) begin
            if (act == SEL_WIDTH'(i)) begin
                act_data = bus.dataIn_data[i*DATA_WIDTH +: DATA_WIDTH];
                act_last = bus.dataIn_last[i];
                rd[i]    = space && act_ok && !rst;
            end
        end
        accept = |(rd & bus.dataIn_vld);
    end

    always_comb begin
        state_d    = state_q;
        cur_sel_d  = cur_sel_q;
        sel_err_d  = sel_err_q;
        out_data_d = out_data_q;
        out_last_d = out_last_q;
        out_vld_d  = out_vld_q;

        // Output register: load on accept, empty out when drained with no refill.
        if (accept) begin
            out_data_d = act_data;
            out_last_d = act_last;
            out_vld_d  = 1'b1;
        end else if (space) begin
            out_vld_d  = 1'b0;
        end

        unique case (state_q)
            S_IDLE: begin
                if (!act_ok) begin
                    sel_err_d = 1'b1;
                end
                if (accept) begin
                    cur_sel_d = sel;
                    // A single-beat frame never leaves idle.
                    if (!act_last) begin
                        state_d = S_LOCKED;
                    end
                end
            end
            S_LOCKED: begin
                if (accept && act_last) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cur_sel_q  <= '0;
            sel_err_q  <= 1'b0;
            out_data_q <= '0;
            out_last_q <= 1'b0;
            out_vld_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cur_sel_q  <= cur_sel_d;
            sel_err_q  <= sel_err_d;
            out_data_q <= out_data_d;
            out_last_q <= out_last_d;
            out_vld_q  <= out_vld_d;
        end
    end

    assign bus.dataIn_rd    = rd;
    assign bus.dataOut_data = out_data_q;
    assign bus.dataOut_last = out_last_q;
    assign bus.dataOut_vld  = out_vld_q;
    assign locked           = (state_q == S_LOCKED);
    assign cur_sel          = cur_sel_q;
    assign sel_err          = sel_err_q;
endmodule

// File: tb/tb_hs_frame_switch_mux.sv
// tb/tb_hs_frame_switch_mux.sv - self-checking bench for hs_frame_switch_mux
module tb_hs_frame_switch_mux;
    localparam int NI = 5;
    localparam int DW = 16;
    localparam int SW = 3;

    logic          clk;
    logic          rst;
    logic [SW-1:0] sel;
    logic          locked;
    logic [SW-1:0] cur_sel;
    logic          sel_err;

    hs_frame_switch_mux_if #(.INPUTS(NI), .DATA_WIDTH(DW)) bus ();

    hs_frame_switch_mux #(.INPUTS(NI), .DATA_WIDTH(DW), .SEL_WIDTH(SW)) dut (
        .clk     (clk),
        .rst     (rst),
        .sel     (sel),
        .bus     (bus),
        .locked  (locked),
        .cur_sel (cur_sel),
        .sel_err (sel_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int i, input logic [DW-1:0] d, input logic l);
        bus.dataIn_data[i*DW +: DW] = d;
        bus.dataIn_last[i]          = l;
        bus.dataIn_vld[i]           = 1'b1;
    endtask

    typedef struct {
        logic [DW-1:0] d;
        logic          l;
    } beat_t;

    beat_t         sbq [NI][$];
    logic          pv  [NI];
    logic [DW-1:0] pd  [NI];
    logic          pl  [NI];
    int            rem [NI];
    int            cnt [NI];

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NI-1:0] rd_s, hs, stall_mask, rd_other;
        logic          ohs, ol, in_frame, out_frame, drain;
        logic [DW-1:0] od;
        int            fsrc, osrc, src;
        beat_t         eb;

        // Reset state, with every input valid to prove rd stays low.
        rst = 1'b1;
        sel = 3'd1;
        bus.dataIn_data = '0;
        bus.dataIn_last = '0;
        bus.dataIn_vld  = '1;
        bus.dataOut_rd  = 1'b1;
        repeat (3) step();
        check("rst_rd", bus.dataIn_rd, 0);
        check("rst_vld", bus.dataOut_vld, 0);
        check("rst_data", bus.dataOut_data, 0);
        check("rst_last", bus.dataOut_last, 0);
        check("rst_locked", locked, 0);
        check("rst_cur_sel", cur_sel, 0);
        check("rst_sel_err", sel_err, 0);

        // Single-beat frame.
        rst = 1'b0;
        bus.dataIn_vld = '0;
        drive(1, 16'h005A, 1'b1);
        #1;
        check("single_rd", bus.dataIn_rd, 5'b00010);
        step();
        bus.dataIn_vld = '0;
        check("single_vld", bus.dataOut_vld, 1);
        check("single_data", bus.dataOut_data, 16'h005A);
        check("single_last", bus.dataOut_last, 1);
        check("single_locked", locked, 0);
        check("single_cur_sel", cur_sel, 1);

        // Frame lock: sel moves to 2 mid-frame while in2 is waiting.
        sel = 3'd0;
        drive(0, 16'h0001, 1'b0);
        drive(2, 16'h0077, 1'b1);
        #1;
        check("lock_rd0", bus.dataIn_rd, 5'b00001);
        step();
        check("lock_d1", bus.dataOut_data, 16'h0001);
        check("lock_locked", locked, 1);
        sel = 3'd2;
        drive(0, 16'h0002, 1'b0);
        #1;
        check("lock_rd1", bus.dataIn_rd, 5'b00001);
        step();
        check("lock_d2", bus.dataOut_data, 16'h0002);
        drive(0, 16'h0003, 1'b1);
        #1;
        check("lock_rd2", bus.dataIn_rd, 5'b00001);
        step();
        check("lock_d3", bus.dataOut_data, 16'h0003);
        check("lock_l3", bus.dataOut_last, 1);
        check("lock_unlocked", locked, 0);
        bus.dataIn_vld[0] = 1'b0;
        #1;
        check("lock_rd_next", bus.dataIn_rd, 5'b00100);
        step();
        check("lock_next_data", bus.dataOut_data, 16'h0077);
        check("lock_next_cur", cur_sel, 2);
        bus.dataIn_vld = '0;

        // Back-pressure mid-frame.
        sel = 3'd3;
        drive(3, 16'h0031, 1'b0);
        step();
        check("bp_d1", bus.dataOut_data, 16'h0031);
        bus.dataOut_rd = 1'b0;
        drive(3, 16'h0032, 1'b0);
        for (int k = 0; k < 3; k++) begin
            #1;
            check("bp_rd", bus.dataIn_rd, 0);
            step();
            check("bp_hold", bus.dataOut_data, 16'h0031);
            check("bp_vld", bus.dataOut_vld, 1);
        end
        bus.dataOut_rd = 1'b1;
        #1;
        check("bp_resume_rd", bus.dataIn_rd, 5'b01000);
        step();
        check("bp_d2", bus.dataOut_data, 16'h0032);
        drive(3, 16'h0033, 1'b1);
        step();
        check("bp_d3", bus.dataOut_data, 16'h0033);
        check("bp_l3", bus.dataOut_last, 1);
        check("bp_unlocked", locked, 0);
        bus.dataIn_vld = '0;

        // Out-of-range sel with every input valid.
        sel = 3'd6;
        bus.dataIn_last = '1;
        bus.dataIn_vld  = '1;
        #1;
        check("oor_rd", bus.dataIn_rd, 0);
        step();
        check("oor_vld", bus.dataOut_vld, 0);
        check("oor_err", sel_err, 1);
        sel = 3'd0;
        drive(0, 16'h000A, 1'b1);
        #1;
        check("oor_back_rd", bus.dataIn_rd, 5'b00001);
        step();
        check("oor_sticky", sel_err, 1);
        check("oor_back_data", bus.dataOut_data, 16'h000A);
        bus.dataIn_vld  = '0;
        bus.dataIn_last = '0;

        // Reset in the middle of a 4-beat frame.
        sel = 3'd1;
        drive(1, 16'h0011, 1'b0);
        step();
        drive(1, 16'h0012, 1'b0);
        step();
        check("mid_locked", locked, 1);
        check("mid_data", bus.dataOut_data, 16'h0012);
        rst = 1'b1;
        drive(1, 16'h0013, 1'b0);
        #1;
        check("mid_rst_rd", bus.dataIn_rd, 0);
        step();
        check("mid_rst_vld", bus.dataOut_vld, 0);
        check("mid_rst_last", bus.dataOut_last, 0);
        check("mid_rst_locked", locked, 0);
        check("mid_rst_err", sel_err, 0);
        rst = 1'b0;
        bus.dataIn_vld = '0;
        sel = 3'd4;
        drive(4, 16'h0044, 1'b1);
        #1;
        check("mid_new_rd", bus.dataIn_rd, 5'b10000);
        step();
        check("mid_new_data", bus.dataOut_data, 16'h0044);
        check("mid_new_cur", cur_sel, 4);
        bus.dataIn_vld = '0;
        step();

        // Random traffic against a per-input beat scoreboard. Each beat
        // carries its source in the top bits and a running count below.
        for (int i = 0; i < NI; i++) begin
            pv[i]  = 1'b0;
            rem[i] = 0;
            cnt[i] = 0;
        end
        in_frame  = 1'b0;
        out_frame = 1'b0;
        fsrc      = 0;
        osrc      = 0;
        for (int cyc = 0; cyc < 12000; cyc++) begin
            drain = (cyc >= 10000);
            for (int i = 0; i < NI; i++) begin
                if (!pv[i] && (rem[i] > 0 || !drain) && ($urandom % 4 != 0)) begin
                    if (rem[i] == 0) rem[i] = 1 + int'($urandom % 4);
                    pd[i] = {3'(i), 13'(cnt[i])};
                    cnt[i]++;
                    pl[i] = (rem[i] == 1);
                    pv[i] = 1'b1;
                end
                bus.dataIn_vld[i]           = pv[i];
                bus.dataIn_data[i*DW +: DW] = pd[i];
                bus.dataIn_last[i]          = pl[i];
            end
            if (!drain && ($urandom % 8 == 0)) sel = 3'(5 + $urandom % 3);
            else                              sel = 3'($urandom % NI);
            bus.dataOut_rd = drain ? 1'b1 : ($urandom % 4 != 0);
            #1;
            rd_s = bus.dataIn_rd;
            check("rnd_rd_onehot", $countones(rd_s) <= 1, 1);
            if (in_frame) begin
                stall_mask = ~(NI'(1) << fsrc);
                rd_other   = rd_s & stall_mask;
                check("rnd_rd_stall", rd_other, 0);
            end
            if (bus.dataOut_vld && !bus.dataOut_rd) check("rnd_rd_bp", rd_s, 0);
            hs  = rd_s & bus.dataIn_vld;
            ohs = bus.dataOut_vld && bus.dataOut_rd;
            od  = bus.dataOut_data;
            ol  = bus.dataOut_last;
            step();
            for (int i = 0; i < NI; i++) begin
                if (hs[i]) begin
                    sbq[i].push_back('{d: pd[i], l: pl[i]});
                    pv[i]    = 1'b0;
                    rem[i]   = rem[i] - 1;
                    in_frame = !pl[i];
                    fsrc     = i;
                end
            end
            if (ohs) begin
                src = int'(od[DW-1 -: 3]);
                check("rnd_src", src < NI, 1);
                if (src < NI) begin
                    check("rnd_avail", sbq[src].size() != 0, 1);
                    if (sbq[src].size() != 0) begin
                        eb = sbq[src].pop_front();
                        check("rnd_data", od, eb.d);
                        check("rnd_last", ol, eb.l);
                    end
                    if (out_frame) check("rnd_contig", src, osrc);
                    out_frame = !ol;
                    osrc      = src;
                end
            end
        end

        for (int i = 0; i < NI; i++) begin
            check("end_sb_left", sbq[i].size(), 0);
            check("end_pending", pv[i], 0);
        end
        check("end_out_vld", bus.dataOut_vld, 0);
        check("end_locked", locked, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
